decode: RTL and testbench
=========================

DECODE -- requirements
Module: decode

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have ports instr  in  32  fetched instruction; pc_i  in  32  its address; instr_valid  in  1  instr/pc_i valid this cycle.
REQ-004 SHALL have port flush  in  1  discard the current instruction (taken branch or jump downstream).
REQ-005 SHALL have ports wb_en  in  1,  wb_dest  in  5,  wb_data  in  32  register write-back from the execute result.
REQ-006 SHALL have registered outputs is_store, is_load, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu  out  1 each  one-hot class flags plus modifiers.
REQ-007 SHALL have registered outputs operand_a, operand_b, branch_dest, store_data, curr_pc  out  32 each; dest  out  5; func3  out  3; func7  out  1.
REQ-008 SHALL have registered outputs valid_o  out  1  outputs hold a real instruction; illegal  out  1  unsupported opcode.

Function
REQ-009 SHALL contain a 32x32 register file; x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-010 SHALL write wb_data to register wb_dest on the clock edge when wb_en=1, including during flush or instr_valid=0.
REQ-011 SHALL, when wb_en=1 and wb_dest equals rs1 or rs2 (nonzero) in the same cycle, use wb_data for that operand (write-through bypass).
REQ-012 SHALL register all outputs one cycle after instr is presented (latency 1); curr_pc SHALL equal the registered pc_i.
REQ-013 SHALL decode LUI: is_ui=1, add_pc=0, operand_a={instr[31:12],12'b0}, dest=rd.
REQ-014 SHALL decode AUIPC: is_ui=1, add_pc=1, operand_a={instr[31:12],12'b0}, dest=rd.
REQ-015 SHALL decode JAL: is_jump=1, is_reg=0, operand_a=sign-extended J-immediate, dest=rd.
REQ-016 SHALL decode JALR: is_jump=1, is_reg=1, operand_a=rs1 value, operand_b=sign-extended I-immediate, dest=rd.
REQ-017 SHALL decode BRANCH: is_branch=1, operand_a=rs1, operand_b=rs2, branch_dest=sign-extended B-immediate, dest=0.
REQ-018 SHALL decode LOAD: is_load=1, operand_a=rs1, operand_b=I-immediate, dest=rd.
REQ-019 SHALL decode STORE: is_store=1, operand_a=rs1, operand_b=sign-extended S-immediate, store_data=rs2, dest=0.
REQ-020 SHALL decode OP: is_alu=1, operand_a=rs1, operand_b=rs2, func7=instr[30], dest=rd.
REQ-021 SHALL decode OP-IMM: is_alu=1, operand_a=rs1, operand_b=sign-extended I-immediate, func7=instr[30] only when func3=101, else 0.
REQ-022 SHALL output func3=instr[14:12] for every decoded class.
REQ-023 SHALL emit a bubble when instr_valid=0 or flush=1: all class flags 0, dest=0, valid_o=0, illegal=0; flush SHALL take priority over instr_valid.
REQ-024 SHALL, for any unlisted opcode with instr_valid=1 and flush=0, emit a bubble with illegal=1 for that one cycle.
REQ-025 SHALL set valid_o=1 for every decoded legal instruction; at most one class flag SHALL be 1 in any cycle.

Reset
REQ-026 SHALL, on reset, clear every output to 0 and all 32 registers to 0 on that clock edge, overriding write-back and instr.
REQ-027 SHALL, on reset deasserting mid-stream, decode the instruction present in the first cycle after reset normally.

Verification
REQ-028 addi x5,x0,42 (0x02A00293) -> next cycle is_alu=1, func3=000, func7=0, operand_a=0, operand_b=42, dest=5, valid_o=1.
REQ-029 wb_en=1, wb_dest=6, wb_data=0x1234 with add x7,x6,x6 (0x006303B3) same cycle -> operand_a=operand_b=0x1234, dest=7.
REQ-030 beq x1,x2,-8 (0xFE208CE3) -> is_branch=1, func3=000, branch_dest=0xFFFFFFF8, dest=0.
REQ-031 lui x10,0x12345 (0x12345537) -> is_ui=1, add_pc=0, operand_a=0x12345000, dest=10; jalr x0,0(x1) (0x00008067) with x1=0x100 -> is_jump=1, is_reg=1, operand_a=0x100, operand_b=0.
REQ-032 instr=0xFFFFFFFF valid -> illegal=1, valid_o=0, flags 0; same instr with flush=1 -> illegal=0.
REQ-033 write x3=0x55, assert reset, then read x3 via add x4,x3,x0 -> operand_a=0; write to x0 then read x0 -> 0.

Source files
------------

// File: rtl/decode.sv
// Instruction decode stage: register file with write-through bypass,
// opcode classification, immediate extraction and a registered output bank.
module decode (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [31:0] pc_i,
    input  logic        instr_valid,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_dest,
    input  logic [31:0] wb_data,
    output logic        is_store,
    output logic        is_load,
    output logic        is_ui,
    output logic        add_pc,
    output logic        is_branch,
    output logic        is_jump,
    output logic        is_reg,
    output logic        is_alu,
    output logic [31:0] operand_a,
    output logic [31:0] operand_b,
    output logic [31:0] branch_dest,
    output logic [31:0] store_data,
    output logic [31:0] curr_pc,
    output logic [4:0]  dest,
    output logic [2:0]  func3,
    output logic        func7,
    output logic        valid_o,
    output logic        illegal
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    logic [4:0]  rs1_s, rs2_s, rd_s;
    logic [6:0]  opcode_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;

    logic        is_store_d, is_load_d, is_ui_d, add_pc_d;
    logic        is_branch_d, is_jump_d, is_reg_d, is_alu_d;
    logic        is_store_q, is_load_q, is_ui_q, add_pc_q;
    logic        is_branch_q, is_jump_q, is_reg_q, is_alu_q;
    logic [31:0] operand_a_d, operand_b_d, branch_dest_d, store_data_d, curr_pc_d;
    logic [31:0] operand_a_q, operand_b_q, branch_dest_q, store_data_q, curr_pc_q;
    logic [4:0]  dest_d, dest_q;
    logic [2:0]  func3_d, func3_q;
    logic        func7_d, func7_q, valid_d, valid_q, illegal_d, illegal_q;

    assign opcode_s = instr[6:0];
    assign rd_s     = instr[11:7];
    assign rs1_s    = instr[19:15];
    assign rs2_s    = instr[24:20];
    assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_u_s  = {instr[31:12], 12'd0};

    // Register file next state: apply write-back, x0 stays hard-wired to zero
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_en && (wb_dest != 5'd0)) begin
            regs_d[wb_dest] = wb_data;
        end else begin
            regs_d[0] = 32'd0;
        end
        regs_d[0] = 32'd0;
    end

    // Source operand read with same-cycle write-back forwarding
    always_comb begin
        if (rs1_s == 5'd0) begin
            rs1_val_s = 32'd0;
        end else if (wb_en && (wb_dest == rs1_s)) begin
            rs1_val_s = wb_data;
        end else begin
            rs1_val_s = regs_q[rs1_s];
        end
        if (rs2_s == 5'd0) begin
            rs2_val_s = 32'd0;
        end else if (wb_en && (wb_dest == rs2_s)) begin
            rs2_val_s = wb_data;
        end else begin
            rs2_val_s = regs_q[rs2_s];
        end
    end

    // Instruction classification and operand selection for the next output bank
    always_comb begin
        is_store_d    = 1'b0;
        is_load_d     = 1'b0;
        is_ui_d       = 1'b0;
        add_pc_d      = 1'b0;
        is_branch_d   = 1'b0;
        is_jump_d     = 1'b0;
        is_reg_d      = 1'b0;
        is_alu_d      = 1'b0;
        operand_a_d   = 32'd0;
        operand_b_d   = 32'd0;
        branch_dest_d = 32'd0;
        store_data_d  = 32'd0;
        curr_pc_d     = pc_i;
        dest_d        = 5'd0;
        func3_d       = 3'd0;
        func7_d       = 1'b0;
        valid_d       = 1'b0;
        illegal_d     = 1'b0;
        if (flush || !instr_valid) begin
            // bubble: every default above already describes it
            valid_d = 1'b0;
        end else begin
            valid_d = 1'b1;
            func3_d = instr[14:12];
            case (opcode_s)
                OPC_LUI: begin
                    is_ui_d     = 1'b1;
                    operand_a_d = imm_u_s;
                    dest_d      = rd_s;
                end
                OPC_AUIPC: begin
                    is_ui_d     = 1'b1;
                    add_pc_d    = 1'b1;
                    operand_a_d = imm_u_s;
                    dest_d      = rd_s;
                end
                OPC_JAL: begin
                    is_jump_d   = 1'b1;
                    operand_a_d = imm_j_s;
                    dest_d      = rd_s;
                end
                OPC_JALR: begin
                    is_jump_d   = 1'b1;
                    is_reg_d    = 1'b1;
                    operand_a_d = rs1_val_s;
                    operand_b_d = imm_i_s;
                    dest_d      = rd_s;
                end
                OPC_BRANCH: begin
                    is_branch_d   = 1'b1;
                    operand_a_d   = rs1_val_s;
                    operand_b_d   = rs2_val_s;
                    branch_dest_d = imm_b_s;
                end
                OPC_LOAD: begin
                    is_load_d   = 1'b1;
                    operand_a_d = rs1_val_s;
                    operand_b_d = imm_i_s;
                    dest_d      = rd_s;
                end
                OPC_STORE: begin
                    is_store_d   = 1'b1;
                    operand_a_d  = rs1_val_s;
                    operand_b_d  = imm_s_s;
                    store_data_d = rs2_val_s;
                end
                OPC_OP: begin
                    is_alu_d    = 1'b1;
                    operand_a_d = rs1_val_s;
                    operand_b_d = rs2_val_s;
                    func7_d     = instr[30];
                    dest_d      = rd_s;
                end
                OPC_OPIMM: begin
                    is_alu_d    = 1'b1;
                    operand_a_d = rs1_val_s;
                    operand_b_d = imm_i_s;
                    // only the shift-right group uses bit 30 as a modifier
                    func7_d     = (instr[14:12] == 3'b101) ? instr[30] : 1'b0;
                    dest_d      = rd_s;
                end
                default: begin
                    valid_d   = 1'b0;
                    func3_d   = 3'd0;
                    illegal_d = 1'b1;
                end
            endcase
        end
    end

    // State update: reset clears the register file and every output
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
            is_store_q    <= 1'b0;
            is_load_q     <= 1'b0;
            is_ui_q       <= 1'b0;
            add_pc_q      <= 1'b0;
            is_branch_q   <= 1'b0;
            is_jump_q     <= 1'b0;
            is_reg_q      <= 1'b0;
            is_alu_q      <= 1'b0;
            operand_a_q   <= 32'd0;
            operand_b_q   <= 32'd0;
            branch_dest_q <= 32'd0;
            store_data_q  <= 32'd0;
            curr_pc_q     <= 32'd0;
            dest_q        <= 5'd0;
            func3_q       <= 3'd0;
            func7_q       <= 1'b0;
            valid_q       <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
            is_store_q    <= is_store_d;
            is_load_q     <= is_load_d;
            is_ui_q       <= is_ui_d;
            add_pc_q      <= add_pc_d;
            is_branch_q   <= is_branch_d;
            is_jump_q     <= is_jump_d;
            is_reg_q      <= is_reg_d;
            is_alu_q      <= is_alu_d;
            operand_a_q   <= operand_a_d;
            operand_b_q   <= operand_b_d;
            branch_dest_q <= branch_dest_d;
            store_data_q  <= store_data_d;
            curr_pc_q     <= curr_pc_d;
            dest_q        <= dest_d;
            func3_q       <= func3_d;
            func7_q       <= func7_d;
            valid_q       <= valid_d;
            illegal_q     <= illegal_d;
        end
    end

    assign is_store    = is_store_q;
    assign is_load     = is_load_q;
    assign is_ui       = is_ui_q;
    assign add_pc      = add_pc_q;
    assign is_branch   = is_branch_q;
    assign is_jump     = is_jump_q;
    assign is_reg      = is_reg_q;
    assign is_alu      = is_alu_q;
    assign operand_a   = operand_a_q;
    assign operand_b   = operand_b_q;
    assign branch_dest = branch_dest_q;
    assign store_data  = store_data_q;
    assign curr_pc     = curr_pc_q;
    assign dest        = dest_q;
    assign func3       = func3_q;
    assign func7       = func7_q;
    assign valid_o     = valid_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode.sv
// Directed-vector bench for the decode stage.
module tb_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, pc_i, wb_data;
    logic        instr_valid, flush, wb_en;
    logic [4:0]  wb_dest;
    logic        is_store, is_load, is_ui, add_pc, is_branch, is_jump, is_reg, is_alu;
    logic [31:0] operand_a, operand_b, branch_dest, store_data, curr_pc;
    logic [4:0]  dest;
    logic [2:0]  func3;
    logic        func7, valid_o, illegal;

    int vec_count = 0;
    int err_count = 0;

    decode dut (
        .clk(clk), .reset(reset), .instr(instr), .pc_i(pc_i), .instr_valid(instr_valid),
        .flush(flush), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .is_store(is_store), .is_load(is_load), .is_ui(is_ui), .add_pc(add_pc),
        .is_branch(is_branch), .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
        .operand_a(operand_a), .operand_b(operand_b), .branch_dest(branch_dest),
        .store_data(store_data), .curr_pc(curr_pc), .dest(dest), .func3(func3),
        .func7(func7), .valid_o(valid_o), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Advance one rising edge, then sample away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_dest = 5'd0; wb_data = 32'd0;
    endtask

    task automatic write_reg(input logic [4:0] r, input logic [31:0] v);
        idle();
        wb_en = 1'b1; wb_dest = r; wb_data = v;
        tick();
        idle();
    endtask

    task automatic issue(input logic [31:0] i, input logic [31:0] pc);
        instr = i; pc_i = pc; instr_valid = 1'b1;
        tick();
    endtask

    function automatic logic [7:0] flags();
        return {is_store, is_load, is_ui, is_branch, is_jump, is_alu, valid_o, illegal};
    endfunction

    task automatic test_reset();
        reset = 1'b1; idle();
        instr = 32'h02A00293; pc_i = 32'h40; instr_valid = 1'b1;
        wb_en = 1'b1; wb_dest = 5'd9; wb_data = 32'hFFFF_FFFF;
        tick(); tick();
        vec_count++; if (flags() !== 8'h00) begin err_count++; $display("FAIL reset_flags: got %h exp 00", flags()); end
        vec_count++; if ({operand_a, operand_b, curr_pc} !== 96'd0) begin err_count++; $display("FAIL reset_data: opa %h opb %h pc %h exp 0", operand_a, operand_b, curr_pc); end
        vec_count++; if ({dest, func3, func7, add_pc, is_reg} !== 11'd0) begin err_count++; $display("FAIL reset_misc: dest %0d f3 %0d exp 0", dest, func3); end
        reset = 1'b0; idle();
        // first instruction after reset is decoded normally; x9 write was overridden
        issue(32'h0004_8233, 32'h44); // add x4,x9,x0
        vec_count++; if (valid_o !== 1'b1 || is_alu !== 1'b1) begin err_count++; $display("FAIL post_reset_valid: valid %b alu %b exp 1 1", valid_o, is_alu); end
        vec_count++; if (operand_a !== 32'd0) begin err_count++; $display("FAIL post_reset_x9: got %h exp 0", operand_a); end
        vec_count++; if (curr_pc !== 32'h44) begin err_count++; $display("FAIL post_reset_pc: got %h exp 44", curr_pc); end
        idle();
    endtask

    task automatic test_alu();
        issue(32'h02A00293, 32'h100); // addi x5,x0,42
        vec_count++; if (flags() !== 8'h06) begin err_count++; $display("FAIL addi_flags: got %h exp 06", flags()); end
        vec_count++; if (func3 !== 3'd0 || func7 !== 1'b0) begin err_count++; $display("FAIL addi_func: f3 %0d f7 %b exp 0 0", func3, func7); end
        vec_count++; if (operand_a !== 32'd0 || operand_b !== 32'd42) begin err_count++; $display("FAIL addi_ops: %h %h exp 0 2a", operand_a, operand_b); end
        vec_count++; if (dest !== 5'd5) begin err_count++; $display("FAIL addi_dest: got %0d exp 5", dest); end
        issue(32'h40000293, 32'h104); // addi x5,x0,1024: bit30 set but func3=000
        vec_count++; if (func7 !== 1'b0 || operand_b !== 32'h400) begin err_count++; $display("FAIL addi_bit30: f7 %b opb %h exp 0 400", func7, operand_b); end
        write_reg(5'd5, 32'h8000_0010);
        issue(32'h4032D293, 32'h108); // srai x5,x5,3
        vec_count++; if (func7 !== 1'b1 || func3 !== 3'b101) begin err_count++; $display("FAIL srai_func: f7 %b f3 %0d exp 1 5", func7, func3); end
        vec_count++; if (operand_a !== 32'h8000_0010 || operand_b !== 32'h403) begin err_count++; $display("FAIL srai_ops: %h %h exp 80000010 403", operand_a, operand_b); end
        idle();
    endtask

    task automatic test_bypass();
        write_reg(5'd6, 32'h9999);
        instr = 32'h006303B3; pc_i = 32'h200; instr_valid = 1'b1; // add x7,x6,x6
        wb_en = 1'b1; wb_dest = 5'd6; wb_data = 32'h1234;
        tick(); idle();
        vec_count++; if (operand_a !== 32'h1234 || operand_b !== 32'h1234) begin err_count++; $display("FAIL bypass_ops: %h %h exp 1234 1234", operand_a, operand_b); end
        vec_count++; if (dest !== 5'd7) begin err_count++; $display("FAIL bypass_dest: got %0d exp 7", dest); end
        issue(32'h406303B3, 32'h204); // sub x7,x6,x6 reads the written value
        vec_count++; if (operand_a !== 32'h1234 || func7 !== 1'b1) begin err_count++; $display("FAIL sub_readback: opa %h f7 %b exp 1234 1", operand_a, func7); end
        idle();
    endtask

    task automatic test_mem_branch();
        write_reg(5'd1, 32'h100);
        write_reg(5'd2, 32'hCAFE);
        issue(32'hFE208CE3, 32'h300); // beq x1,x2,-8
        vec_count++; if (flags() !== 8'h12) begin err_count++; $display("FAIL beq_flags: got %h exp 12", flags()); end
        vec_count++; if (branch_dest !== 32'hFFFF_FFF8 || dest !== 5'd0 || func3 !== 3'd0) begin err_count++; $display("FAIL beq_fields: bd %h dest %0d f3 %0d exp fffffff8 0 0", branch_dest, dest, func3); end
        vec_count++; if (operand_a !== 32'h100 || operand_b !== 32'hCAFE) begin err_count++; $display("FAIL beq_ops: %h %h exp 100 cafe", operand_a, operand_b); end
        issue(32'hFE20AE23, 32'h304); // sw x2,-4(x1)
        vec_count++; if (flags() !== 8'h82) begin err_count++; $display("FAIL sw_flags: got %h exp 82", flags()); end
        vec_count++; if (operand_a !== 32'h100 || operand_b !== 32'hFFFF_FFFC) begin err_count++; $display("FAIL sw_ops: %h %h exp 100 fffffffc", operand_a, operand_b); end
        vec_count++; if (store_data !== 32'hCAFE || dest !== 5'd0 || func3 !== 3'b010) begin err_count++; $display("FAIL sw_fields: sd %h dest %0d f3 %0d exp cafe 0 2", store_data, dest, func3); end
        issue(32'hFF00A403, 32'h308); // lw x8,-16(x1)
        vec_count++; if (flags() !== 8'h42) begin err_count++; $display("FAIL lw_flags: got %h exp 42", flags()); end
        vec_count++; if (operand_a !== 32'h100 || operand_b !== 32'hFFFF_FFF0 || dest !== 5'd8) begin err_count++; $display("FAIL lw_fields: %h %h %0d exp 100 fffffff0 8", operand_a, operand_b, dest); end
        idle();
    endtask

    task automatic test_upper_jump();
        issue(32'h12345537, 32'h400); // lui x10,0x12345
        vec_count++; if (flags() !== 8'h22 || add_pc !== 1'b0) begin err_count++; $display("FAIL lui_flags: got %h add_pc %b exp 22 0", flags(), add_pc); end
        vec_count++; if (operand_a !== 32'h1234_5000 || dest !== 5'd10) begin err_count++; $display("FAIL lui_fields: %h %0d exp 12345000 10", operand_a, dest); end
        issue(32'hABCDE597, 32'h404); // auipc x11,0xABCDE
        vec_count++; if (is_ui !== 1'b1 || add_pc !== 1'b1 || operand_a !== 32'hABCD_E000 || dest !== 5'd11) begin err_count++; $display("FAIL auipc: ui %b apc %b opa %h dest %0d exp 1 1 abcde000 11", is_ui, add_pc, operand_a, dest); end
        vec_count++; if (curr_pc !== 32'h404) begin err_count++; $display("FAIL auipc_pc: got %h exp 404", curr_pc); end
        issue(32'hFFDFF0EF, 32'h408); // jal x1,-4
        vec_count++; if (is_jump !== 1'b1 || is_reg !== 1'b0 || operand_a !== 32'hFFFF_FFFC || dest !== 5'd1) begin err_count++; $display("FAIL jal: j %b r %b opa %h dest %0d exp 1 0 fffffffc 1", is_jump, is_reg, operand_a, dest); end
        issue(32'h00008067, 32'h40C); // jalr x0,0(x1), x1=0x100
        vec_count++; if (flags() !== 8'h0A || is_reg !== 1'b1) begin err_count++; $display("FAIL jalr_flags: got %h reg %b exp 0a 1", flags(), is_reg); end
        vec_count++; if (operand_a !== 32'h100 || operand_b !== 32'd0 || dest !== 5'd0) begin err_count++; $display("FAIL jalr_ops: %h %h %0d exp 100 0 0", operand_a, operand_b, dest); end
        idle();
    endtask

    task automatic test_illegal_flush();
        issue(32'hFFFF_FFFF, 32'h500);
        vec_count++; if (flags() !== 8'h01 || dest !== 5'd0) begin err_count++; $display("FAIL illegal_flags: got %h dest %0d exp 01 0", flags(), dest); end
        flush = 1'b1;
        issue(32'hFFFF_FFFF, 32'h504);
        vec_count++; if (flags() !== 8'h00) begin err_count++; $display("FAIL illegal_flush: got %h exp 00", flags()); end
        issue(32'h02A00293, 32'h508); // legal instr flushed
        vec_count++; if (flags() !== 8'h00 || dest !== 5'd0) begin err_count++; $display("FAIL flush_bubble: got %h dest %0d exp 00 0", flags(), dest); end
        flush = 1'b0;
        issue(32'hFFFF_FFFF, 32'h50C);
        instr_valid = 1'b0;
        tick();
        vec_count++; if (flags() !== 8'h00) begin err_count++; $display("FAIL illegal_one_cycle: got %h exp 00", flags()); end
        idle();
    endtask

    task automatic test_reg_reset_x0();
        write_reg(5'd3, 32'h55);
        issue(32'h0001_8233, 32'h600); // add x4,x3,x0
        vec_count++; if (operand_a !== 32'h55) begin err_count++; $display("FAIL x3_written: got %h exp 55", operand_a); end
        reset = 1'b1; wb_en = 1'b1; wb_dest = 5'd3; wb_data = 32'h77;
        tick();
        vec_count++; if (valid_o !== 1'b0 || operand_a !== 32'd0) begin err_count++; $display("FAIL reset_midstream: valid %b opa %h exp 0 0", valid_o, operand_a); end
        reset = 1'b0; idle();
        issue(32'h0001_8233, 32'h604);
        vec_count++; if (operand_a !== 32'd0 || valid_o !== 1'b1 || dest !== 5'd4) begin err_count++; $display("FAIL x3_after_reset: opa %h valid %b dest %0d exp 0 1 4", operand_a, valid_o, dest); end
        write_reg(5'd0, 32'hDEAD);
        instr = 32'h0000_0233; pc_i = 32'h608; instr_valid = 1'b1; // add x4,x0,x0
        wb_en = 1'b1; wb_dest = 5'd0; wb_data = 32'hBEEF;
        tick(); idle();
        vec_count++; if (operand_a !== 32'd0 || operand_b !== 32'd0) begin err_count++; $display("FAIL x0_read: %h %h exp 0 0", operand_a, operand_b); end
    endtask

    task automatic test_back_to_back();
        instr = 32'h02A00293; pc_i = 32'h700; instr_valid = 1'b1;
        tick();
        vec_count++; if (is_alu !== 1'b1 || dest !== 5'd5 || curr_pc !== 32'h700) begin err_count++; $display("FAIL b2b_first: alu %b dest %0d pc %h exp 1 5 700", is_alu, dest, curr_pc); end
        instr = 32'h12345537; pc_i = 32'h704;
        tick();
        vec_count++; if (flags() !== 8'h22 || dest !== 5'd10 || curr_pc !== 32'h704) begin err_count++; $display("FAIL b2b_second: flags %h dest %0d pc %h exp 22 10 704", flags(), dest, curr_pc); end
        idle();
        tick();
        vec_count++; if (flags() !== 8'h00) begin err_count++; $display("FAIL b2b_idle: got %h exp 00", flags()); end
    endtask

    initial begin
        instr = 32'd0; pc_i = 32'd0; idle(); reset = 1'b1;
        test_reset();
        test_alu();
        test_bypass();
        test_mem_branch();
        test_upper_jump();
        test_illegal_flush();
        test_reg_reset_x0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
